// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request, grant and routing signals between the two masters and the arbiter
interface bus_arbiter_if;
  logic       m1_req;
  logic       m2_req;
  logic [1:0] m1_slave_sel;
  logic [1:0] m2_slave_sel;
  logic [2:0] slave_ready;
  logic       m1_grant;
  logic       m2_grant;
  logic       m1_err;
  logic       m2_err;
  logic       bus_owner;
  logic [1:0] slave_sel;
  logic       bus_busy;
  logic       timeout;
  modport slave (
    input  m1_req, m2_req, m1_slave_sel, m2_slave_sel, slave_ready,
    output m1_grant, m2_grant, m1_err, m2_err, bus_owner, slave_sel, bus_busy, timeout
  );
  modport master (
    output m1_req, m2_req, m1_slave_sel, m2_slave_sel, slave_ready,
    input  m1_grant, m2_grant, m1_err, m2_err, bus_owner, slave_sel, bus_busy, timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin serial bus arbiter with ready gating and hold watchdog
module bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, M1_OWN, M2_OWN, RELEASE} state_t;
  state_t     state_q, state_d;
  logic       m1_grant_q, m1_grant_d, m2_grant_q, m2_grant_d;
  logic       m1_err_q, m1_err_d, m2_err_q, m2_err_d;
  logic       bus_owner_q, bus_owner_d, bus_busy_q, bus_busy_d;
  logic       timeout_q, timeout_d, last_owner_q, last_owner_d;
  logic       m1_lock_q, m1_lock_d, m2_lock_q, m2_lock_d;
  logic [1:0] slave_sel_q, slave_sel_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] rdy;
  logic       m1_cand, m2_cand, pick_m1, pick_m2, own_req;
  assign rdy     = {1'b0, bus.slave_ready};
  assign m1_cand = bus.m1_req && bus.m1_slave_sel != 2'd3 && rdy[bus.m1_slave_sel] && !m1_lock_q;
  assign m2_cand = bus.m2_req && bus.m2_slave_sel != 2'd3 && rdy[bus.m2_slave_sel] && !m2_lock_q;
  assign pick_m1 = m1_cand && (!m2_cand || last_owner_q);
  assign pick_m2 = m2_cand && !pick_m1;
  assign own_req = (state_q == M1_OWN) ? bus.m1_req : bus.m2_req;
  // next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    m1_grant_d   = 1'b0;
    m2_grant_d   = 1'b0;
    m1_err_d     = 1'b0;
    m2_err_d     = 1'b0;
    bus_owner_d  = bus_owner_q;
    slave_sel_d  = 2'd3;
    timeout_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    m1_lock_d    = m1_lock_q;
    m2_lock_d    = m2_lock_q;
    case (state_q)
      IDLE: begin
        m1_err_d = bus.m1_req && bus.m1_slave_sel == 2'd3;
        m2_err_d = bus.m2_req && bus.m2_slave_sel == 2'd3;
        if (pick_m1 || pick_m2) begin
          state_d      = pick_m1 ? M1_OWN : M2_OWN;
          m1_grant_d   = pick_m1;
          m2_grant_d   = pick_m2;
          bus_owner_d  = pick_m2;
          last_owner_d = pick_m2;
          slave_sel_d  = pick_m1 ? bus.m1_slave_sel : bus.m2_slave_sel;
          hold_cnt_d   = 8'd0;
        end
      end
      M1_OWN, M2_OWN: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (!own_req) begin
          state_d = RELEASE;
        end else if (hold_cnt_q == TIMEOUT - 8'd1) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
          m1_lock_d = m1_lock_q | (state_q == M1_OWN);
          m2_lock_d = m2_lock_q | (state_q == M2_OWN);
        end else begin
          m1_grant_d  = m1_grant_q;
          m2_grant_d  = m2_grant_q;
          slave_sel_d = slave_sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
    bus_busy_d = state_d != IDLE;
    if (!bus.m1_req) m1_lock_d = 1'b0;
    if (!bus.m2_req) m2_lock_d = 1'b0;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      m1_grant_q   <= 1'b0;
      m2_grant_q   <= 1'b0;
      m1_err_q     <= 1'b0;
      m2_err_q     <= 1'b0;
      bus_owner_q  <= 1'b0;
      slave_sel_q  <= 2'd3;
      bus_busy_q   <= 1'b0;
      timeout_q    <= 1'b0;
      hold_cnt_q   <= 8'd0;
      last_owner_q <= 1'b1;
      m1_lock_q    <= 1'b0;
      m2_lock_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      m1_grant_q   <= m1_grant_d;
      m2_grant_q   <= m2_grant_d;
      m1_err_q     <= m1_err_d;
      m2_err_q     <= m2_err_d;
      bus_owner_q  <= bus_owner_d;
      slave_sel_q  <= slave_sel_d;
      bus_busy_q   <= bus_busy_d;
      timeout_q    <= timeout_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      m1_lock_q    <= m1_lock_d;
      m2_lock_q    <= m2_lock_d;
    end
  end
  assign bus.m1_grant  = m1_grant_q;
  assign bus.m2_grant  = m2_grant_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.m2_err    = m2_err_q;
  assign bus.bus_owner = bus_owner_q;
  assign bus.slave_sel = slave_sel_q;
  assign bus.bus_busy  = bus_busy_q;
  assign bus.timeout   = timeout_q;
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, three-slave arbiter for the serial system bus. It picks which master owns the shared serial address/data lines and routes them to the target slave. The master-to-slave muxes elsewhere are steered by `bus_owner` and `slave_sel`. A grant is issued only when the target slave port reports `slave_ready`. Round-robin fairness and a hold-time watchdog stop either master from starving the other.

## Interface
Parameters:
- `TIMEOUT`, default 8'd200: maximum consecutive grant cycles per ownership. Legal range is 2..255.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `m1_req`, in, 1: master 1 bus request. It is held for the whole transaction.
- `m2_req`, in, 1: master 2 bus request.
- `m1_slave_sel`, in, 2: master 1 target slave, 0..2. Value 3 is invalid.
- `m2_slave_sel`, in, 2: master 2 target slave.
- `slave_ready`, in, 3: per-slave idle flag. Bit n comes from slave n's input port `slave_ready`.
- `m1_grant`, out, 1: master 1 owns the bus.
- `m2_grant`, out, 1: master 2 owns the bus.
- `m1_err`, out, 1: one-cycle pulse when master 1 requests with an invalid `slave_sel`.
- `m2_err`, out, 1: same as `m1_err`, for master 2.
- `bus_owner`, out, 1: 0 = master 1, 1 = master 2. Meaningful only while a grant is high.
- `slave_sel`, out, 2: slave currently routed. 2'd3 = none.
- `bus_busy`, out, 1: high during ownership and the release turnaround.
- `timeout`, out, 1: one-cycle pulse when ownership is revoked by the watchdog.

## Operation
- States are IDLE, M1_OWN, M2_OWN and RELEASE. All outputs are registered.
- Reset values:
  - State is IDLE.
  - Grants, errs, `timeout`, `bus_busy`, `bus_owner` and `hold_cnt` are all 0.
  - `slave_sel` is 3.
  - `last_owner` is 1, so master 1 wins the first tie.
  - Lock flags `m1_lock` and `m2_lock` are 0.
- Candidate rule: a master is a candidate in IDLE when all of the following hold:
  - its req = 1;
  - its sel is not 3;
  - `slave_ready[sel]` = 1;
  - its lock = 0.
- IDLE, one candidate: grant that master.
  - Go to Mx_OWN.
  - Latch `bus_owner` and `slave_sel` from that master's sel.
  - Set `last_owner` to that master.
  - Clear `hold_cnt` to 0.
- IDLE, two candidates: grant the master that is not `last_owner`.
- IDLE, no candidate: stay in IDLE.
- Invalid sel: a master with req = 1 and sel = 3 pulses its err in every IDLE cycle in which this holds. It is never granted. The other master is unaffected.
- Slave not ready: a requester whose slave is not ready waits in IDLE with no err.
- Mx_OWN:
  - The grant stays high.
  - `slave_sel` is frozen. Changes on the master's sel input are ignored.
  - `hold_cnt` increments by 1 each cycle, 8-bit, no wrap within the legal range.
  - The other master's req is ignored.
  - If owner req = 0: go to RELEASE.
  - Else if `hold_cnt` = TIMEOUT-1: pulse `timeout`, set the owner's lock, go to RELEASE.
  - Else: stay.
- RELEASE:
  - Lasts one cycle.
  - Grants are 0, `slave_sel` is 3, `bus_busy` is 1.
  - Always goes to IDLE.
- Lock: a master's lock clears on any edge where its req is sampled 0. A timed-out master must therefore drop req for at least one cycle before it can be granted again.
- `bus_busy` is 1 in M1_OWN, M2_OWN and RELEASE, and 0 in IDLE.
- `slave_ready` is checked only at grant time. It is not monitored during ownership, because the slave drops it once its receive starts.

## Timing
- Grant latency: a candidate sampled at edge k in IDLE gives a grant high from edge k onward, i.e. visible in cycle k+1. `slave_sel` and `bus_owner` change on the same edge.
- Release: owner req sampled low at edge j drops the grant and `slave_sel` (to 3) at edge j.
  - Edge j+1 enters IDLE.
  - The earliest next grant is at edge j+2.
- Watchdog: the grant is high for exactly TIMEOUT cycles when req is never dropped. `timeout` is high for the single cycle after the revoking edge.
- Err pulses are registered, one cycle after sampling.
- Reset mid-ownership: at the reset edge the grant drops, state goes to IDLE, locks clear and `last_owner` becomes 1. No RELEASE cycle occurs.
- Simultaneous release and other-master request: the new grant is still issued no earlier than edge j+2.

## Test plan
- Reset check: assert reset for 2 cycles with both reqs high. Required response: grants 0, `slave_sel` = 3, `bus_busy` = 0, errs 0, `timeout` 0.
- Single transfer:
  - Stimulus: `m1_req` = 1, `m1_slave_sel` = 1, `slave_ready` = 3'b010.
  - Required: `m1_grant` = 1 one edge later, with `slave_sel` = 1 and `bus_owner` = 0.
  - Then drop req after 20 cycles. Required: grant = 0 on the next edge, and `bus_busy` = 0 one edge after that.
- Round-robin:
  - Stimulus: both reqs high, sel 0 and 2, all slaves ready.
  - Required: master 1 granted first.
  - On master 1 release, `m2_grant` rises 2 edges after the drop edge.
  - With both requesting again after master 2 releases, master 1 is granted.
- Invalid select: `m2_slave_sel` = 3 with `m2_req` held for 4 IDLE cycles. Required: `m2_err` high in 4 cycles and `m2_grant` never high. Master 1 is granted normally in parallel.
- Watchdog:
  - Stimulus: TIMEOUT = 8, `m1_req` held high continuously, `m2_req` high.
  - Required: `m1_grant` high exactly 8 cycles, then a one-cycle `timeout` pulse, and master 2 granted next.
  - Master 1 is not regranted until `m1_req` goes low for 1 cycle.
- Ready gating and reset: `m1_slave_sel` = 2 with `slave_ready[2]` = 0 for 5 cycles.
  - Required: no grant. Set the ready bit to 1, and the grant rises on the next edge.
  - Then pulse reset mid-ownership. Required: grant = 0 and `slave_sel` = 3 at that edge.
